alu_sar_search: RTL

Successive-approximation search engine that drives the ALU's unsigned greater-than comparator from the query side. It issues a probe value each step and consumes the comparator's 1-bit verdict. After WIDTH steps it produces the exact value of the comparator's hidden operand. It sits beside the comparator in the ALU datapath: the comparator's `a` input carries the target, `b` carries `probe`, and `y[0]` returns as `gt`. Typical uses are integer reconstruction, threshold discovery and comparator self-test.

---
 rtl/alu_sar_search.sv | 64 ++++++
 1 files changed

// File: rtl/alu_sar_search.sv
// alu_sar_search: successive-approximation search that reconstructs a comparator's hidden operand
module alu_sar_search #(
  parameter int WIDTH   = 32,
  parameter int CMP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             gt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, PROBE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] r, r_n;
  logic [IW-1:0] i, i_n;
  logic sample;
  function automatic logic [WIDTH-1:0] low_mask(input logic [IW-1:0] n);
    logic [WIDTH-1:0] m;
    for (int j = 0; j < WIDTH; j++) m[j] = j < int'(n);
    return m;
  endfunction
  always_comb begin
    sample = (state == WAIT) || (state == PROBE && CMP_LAT == 0);
    state_n = state;
    r_n = r;
    i_n = i;
    case (state)
      IDLE: if (start) begin
        state_n = PROBE;
        r_n = '0;
        i_n = IW'(WIDTH - 1);
      end
      PROBE, WAIT: if (!sample) state_n = WAIT;
      else begin
        r_n = gt ? r | (WIDTH'(1) << i) : r;
        state_n = (i == '0) ? DONE : PROBE;
        i_n = (i == '0) ? i : i - IW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state == PROBE) || (state == WAIT);
  assign done = state == DONE;
  // probe is registered from next-state values so it is stable for the whole step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      i <= '0;
      probe <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      r <= r_n;
      i <= i_n;
      probe <= (state_n == PROBE || state_n == WAIT) ? r_n | low_mask(i_n) : '0;
      result <= (state_n == DONE) ? r_n : result;
    end
  end
endmodule
